// File: rtl/bus_strobe_sync.sv
// Host bus strobe/data synchronizer into the osc domain, with address latch,
// write transaction queue and single-cycle read request.
module bus_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned LVL_W       = 3
) (
    input  logic             osc,
    input  logic             rst,
    input  logic [7:0]       bus_data_in,
    input  logic             bus_ale,
    input  logic             bus_write,
    input  logic             bus_read,
    output logic             wr_valid,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    input  logic             wr_ready,
    output logic             rd_req,
    output logic [7:0]       rd_addr,
    output logic             rd_addr_ok,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENT_W = 16;

    logic [SYNC_STAGES-1:0] ale_sync;
    logic [SYNC_STAGES-1:0] write_sync;
    logic [SYNC_STAGES-1:0] read_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   ale_d;
    logic                   write_d;
    logic                   read_d;

    logic [7:0]             addr_q;
    logic [ENT_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level_q;
    logic                   ovf_q;
    logic                   rd_req_q;

    logic                   ale_s_c;
    logic                   write_s_c;
    logic                   read_s_c;
    logic [7:0]             data_al_c;
    logic                   ale_fall_c;
    logic                   write_rise_c;
    logic                   read_fall_c;
    logic [7:0]             push_addr_c;
    logic                   full_c;
    logic                   pop_c;
    logic                   push_c;
    logic                   drop_c;

    // Synchronizer chains; data runs in parallel so it stays aligned with the strobes.
    always_ff @(posedge osc) begin
        if (rst) begin
            ale_sync   <= '0;
            write_sync <= '1;
            read_sync  <= '1;
            ale_d      <= 1'b0;
            write_d    <= 1'b1;
            read_d     <= 1'b1;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                data_sync[i] <= '0;
            end
        end else begin
            ale_sync   <= {ale_sync[SYNC_STAGES-2:0], bus_ale};
            write_sync <= {write_sync[SYNC_STAGES-2:0], bus_write};
            read_sync  <= {read_sync[SYNC_STAGES-2:0], bus_read};
            ale_d      <= ale_s_c;
            write_d    <= write_s_c;
            read_d     <= read_s_c;
            data_sync[0] <= bus_data_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    always_comb begin
        ale_s_c      = ale_sync[SYNC_STAGES-1];
        write_s_c    = write_sync[SYNC_STAGES-1];
        read_s_c     = read_sync[SYNC_STAGES-1];
        data_al_c    = data_sync[SYNC_STAGES-1];
        ale_fall_c   = ale_d & ~ale_s_c;
        write_rise_c = ~write_d & write_s_c;
        read_fall_c  = read_d & ~read_s_c;
        // A same-cycle ALE fall supplies the address of this write.
        push_addr_c  = ale_fall_c ? data_al_c : addr_q;
        full_c       = (level_q == LVL_W'(FIFO_DEPTH));
        pop_c        = (level_q != '0) & wr_ready;
        push_c       = write_rise_c & (~full_c | pop_c);
        drop_c       = write_rise_c & full_c & ~pop_c;
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            addr_q   <= '0;
            rd_req_q <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (ale_fall_c) begin
                addr_q <= data_al_c;
            end
            rd_req_q <= read_fall_c;
            if (push_c) begin
                mem[wr_ptr] <= {push_addr_c, data_al_c};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop_c && !push_c) begin
                level_q <= level_q - LVL_W'(1);
            end
            // A drop in the same cycle as clear_ovf keeps the flag set.
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign wr_valid   = (level_q != '0);
    assign wr_addr    = mem[rd_ptr][15:8];
    assign wr_data    = mem[rd_ptr][7:0];
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = addr_q;
    assign rd_addr_ok = addr_q[4];

endmodule

// File: tb/tb_bus_strobe_sync.sv
// Directed self-checking bench for bus_strobe_sync.
module tb_bus_strobe_sync;

    logic       osc;
    logic       rst;
    logic [7:0] bus_data_in;
    logic       bus_ale;
    logic       bus_write;
    logic       bus_read;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_addr_ok;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       clear_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    bus_strobe_sync #(.SYNC_STAGES(2), .FIFO_DEPTH(4), .LVL_W(3)) dut (
        .osc(osc), .rst(rst), .bus_data_in(bus_data_in), .bus_ale(bus_ale),
        .bus_write(bus_write), .bus_read(bus_read), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_addr_ok(rd_addr_ok), .fifo_level(fifo_level),
        .overflow(overflow), .clear_ovf(clear_ovf)
    );

    initial begin
        osc = 1'b0;
        forever #5 osc = ~osc;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge osc);
    endtask

    task automatic bus_addr(input logic [7:0] a);
        bus_data_in = a;
        cyc(4);
        bus_ale = 1'b1;
        cyc(4);
        bus_ale = 1'b0;
        cyc(4);
    endtask

    task automatic bus_wr(input logic [7:0] d);
        bus_data_in = d;
        cyc(4);
        bus_write = 1'b0;
        cyc(4);
        bus_write = 1'b1;
        cyc(4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n_tests++;
            if ({wr_valid, wr_addr, wr_data, rd_req, rd_addr, rd_addr_ok, fifo_level, overflow} !== 30'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got wr_valid=%b wr_addr=%h wr_data=%h rd_req=%b rd_addr=%h ok=%b level=%0d ovf=%b want all 0",
                         i, wr_valid, wr_addr, wr_data, rd_req, rd_addr, rd_addr_ok, fifo_level, overflow);
            end
        end
    endtask

    task automatic test_single_write;
        wr_ready = 1'b1;
        bus_addr(8'h12);
        bus_data_in = 8'hA5;
        cyc(4);
        bus_write = 1'b0;
        cyc(4);
        bus_write = 1'b1;
        cyc(2);
        n_tests++;
        if (wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_early got wr_valid=%b want 0", wr_valid);
        end
        cyc(1);
        n_tests++;
        if ({wr_valid, wr_addr, wr_data, fifo_level} !== {1'b1, 8'h12, 8'hA5, 3'd1}) begin
            n_fail++;
            $display("FAIL wr_latency got valid=%b addr=%h data=%h level=%0d want 1 12 a5 1",
                     wr_valid, wr_addr, wr_data, fifo_level);
        end
        cyc(1);
        n_tests++;
        if ({wr_valid, fifo_level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL wr_pop got valid=%b level=%0d want 0 0", wr_valid, fifo_level);
        end
        cyc(3);
    endtask

    task automatic test_overflow;
        wr_ready = 1'b0;
        bus_addr(8'h10);
        for (int d = 1; d <= 5; d++) bus_wr(8'(d));
        n_tests++;
        if ({wr_valid, fifo_level, overflow} !== {1'b1, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_full got valid=%b level=%0d ovf=%b want 1 4 1", wr_valid, fifo_level, overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h10, 8'(i)}) begin
                n_fail++;
                $display("FAIL ovf_pop%0d got valid=%b addr=%h data=%h want 1 10 %h",
                         i, wr_valid, wr_addr, wr_data, 8'(i));
            end
            wr_ready = 1'b1;
            cyc(1);
            wr_ready = 1'b0;
        end
        n_tests++;
        if ({wr_valid, fifo_level, overflow} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_sticky got valid=%b level=%0d ovf=%b want 0 0 1", wr_valid, fifo_level, overflow);
        end
        clear_ovf = 1'b1;
        cyc(1);
        clear_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop;
        wr_ready = 1'b0;
        for (int d = 8'h21; d <= 8'h24; d++) bus_wr(8'(d));
        n_tests++;
        if ({fifo_level, overflow} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL fpp_fill got level=%0d ovf=%b want 4 0", fifo_level, overflow);
        end
        bus_data_in = 8'h25;
        cyc(4);
        bus_write = 1'b0;
        cyc(4);
        bus_write = 1'b1;
        cyc(2);
        wr_ready = 1'b1;
        cyc(1);
        wr_ready = 1'b0;
        n_tests++;
        if ({fifo_level, overflow, wr_data} !== {3'd4, 1'b0, 8'h22}) begin
            n_fail++;
            $display("FAIL fpp_same got level=%0d ovf=%b head=%h want 4 0 22", fifo_level, overflow, wr_data);
        end
        cyc(4);
        for (int d = 8'h22; d <= 8'h25; d++) begin
            n_tests++;
            if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h10, 8'(d)}) begin
                n_fail++;
                $display("FAIL fpp_order got valid=%b addr=%h data=%h want 1 10 %h", wr_valid, wr_addr, wr_data, 8'(d));
            end
            wr_ready = 1'b1;
            cyc(1);
            wr_ready = 1'b0;
        end
        n_tests++;
        if ({wr_valid, fifo_level, overflow} !== {1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL fpp_drain got valid=%b level=%0d ovf=%b want 0 0 0", wr_valid, fifo_level, overflow);
        end
    endtask

    task automatic test_read;
        int pulses;
        bus_addr(8'h1D);
        bus_read = 1'b0;
        cyc(2);
        n_tests++;
        if (rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_early got rd_req=%b want 0", rd_req);
        end
        cyc(1);
        n_tests++;
        if ({rd_req, rd_addr, rd_addr_ok} !== {1'b1, 8'h1D, 1'b1}) begin
            n_fail++;
            $display("FAIL rd_pulse got req=%b addr=%h ok=%b want 1 1d 1", rd_req, rd_addr, rd_addr_ok);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (rd_req === 1'b1) pulses++;
        end
        bus_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (rd_req === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL rd_single got %0d extra rd_req cycles want 0", pulses);
        end
        bus_addr(8'h0D);
        bus_read = 1'b0;
        cyc(3);
        n_tests++;
        if ({rd_req, rd_addr, rd_addr_ok} !== {1'b1, 8'h0D, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_addr_bad got req=%b addr=%h ok=%b want 1 0d 0", rd_req, rd_addr, rd_addr_ok);
        end
        bus_read = 1'b1;
        cyc(4);
    endtask

    task automatic test_forward;
        wr_ready = 1'b0;
        bus_data_in = 8'h44;
        cyc(4);
        bus_ale = 1'b1;
        bus_write = 1'b0;
        cyc(4);
        bus_ale = 1'b0;
        bus_write = 1'b1;
        cyc(4);
        n_tests++;
        if ({wr_valid, wr_addr, wr_data, rd_addr} !== {1'b1, 8'h44, 8'h44, 8'h44}) begin
            n_fail++;
            $display("FAIL fwd got valid=%b addr=%h data=%h rd_addr=%h want 1 44 44 44",
                     wr_valid, wr_addr, wr_data, rd_addr);
        end
        wr_ready = 1'b1;
        cyc(1);
        wr_ready = 1'b0;
    endtask

    task automatic test_reset_midflight;
        wr_ready = 1'b0;
        bus_addr(8'h30);
        for (int d = 1; d <= 3; d++) bus_wr(8'(8'h30 + d));
        n_tests++;
        if (fifo_level !== 3'd3) begin
            n_fail++;
            $display("FAIL rstm_fill got level=%0d want 3", fifo_level);
        end
        bus_write = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        n_tests++;
        if ({wr_valid, fifo_level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL rstm_clear got valid=%b level=%0d want 0 0", wr_valid, fifo_level);
        end
        bus_write = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(8);
        n_tests++;
        if ({wr_valid, fifo_level, overflow, rd_addr} !== {1'b0, 3'd0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rstm_nopush got valid=%b level=%0d ovf=%b rd_addr=%h want 0 0 0 00",
                     wr_valid, fifo_level, overflow, rd_addr);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus_data_in = 8'h00;
        bus_ale     = 1'b0;
        bus_write   = 1'b1;
        bus_read    = 1'b1;
        wr_ready    = 1'b0;
        clear_ovf   = 1'b0;
        test_reset;
        test_single_write;
        test_overflow;
        test_full_push_pop;
        test_read;
        test_forward;
        test_reset_midflight;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
